// File: rtl/sysmm_pkg.sv
// sysmm_pkg: shared FSM state type and default accumulator-width helper.
package sysmm_pkg;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

    function automatic int acc_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_matmul_nxn_if.sv
// systolic_matmul_nxn_if: operand/result streaming handshakes plus status.
interface systolic_matmul_nxn_if #(
    parameter int DW   = 4,
    parameter int ACCW = sysmm_pkg::acc_w(2, DW)
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic            busy;
    logic            done;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, busy, done);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, busy, done);
endinterface

// File: rtl/sysmm_pe.sv
// sysmm_pe: one multiply-accumulate cell; SYSMM_SIGNED_EN selects two's-complement operands.
module sysmm_pe #(
    parameter int DW   = 4,
    parameter int ACCW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr_acc,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [ACCW-1:0] acc
);
    logic [2*DW-1:0] w_p;
    logic [ACCW-1:0] w_ext;

`ifdef SYSMM_SIGNED_EN
    assign w_p   = $signed(a_in) * $signed(b_in);
    assign w_ext = {{(ACCW-2*DW){w_p[2*DW-1]}}, w_p};
`else
    assign w_p   = a_in * b_in;
    assign w_ext = {{(ACCW-2*DW){1'b0}}, w_p};
`endif

    // Accumulate and forward operands while computing; wipe between products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr_acc) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + w_ext;
        end
    end
endmodule

// File: rtl/systolic_matmul_nxn.sv
// systolic_matmul_nxn: NxN output-stationary systolic C = A x B; SYSMM_SIGNED_EN enables signed operands.
module systolic_matmul_nxn import sysmm_pkg::*; #(
    parameter int N    = 2,
    parameter int DW   = 4,
    parameter int ACCW = acc_w(N, DW)
) (
    input logic clk,
    input logic rst_n,
    input logic clr,
    systolic_matmul_nxn_if.slave bus
);
    localparam int NN = N * N;
    localparam int CW = $clog2(NN);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_live;
    logic [DW-1:0]   r_a [NN];
    logic [DW-1:0]   r_b [NN];
    logic [DW-1:0]   w_al [N];
    logic [DW-1:0]   w_bt [N];
    logic [DW-1:0]   w_ah [N][N];
    logic [DW-1:0]   w_bv [N][N];
    logic [ACCW-1:0] w_acc [NN];
    logic            w_last, w_cmp_end, w_in_xfer, w_out_xfer, w_unused;

    assign w_last     = r_cnt == CW'(NN - 1);
    assign w_cmp_end  = r_cnt == CW'(3 * N - 3);
    assign w_in_xfer  = bus.in_valid && bus.in_ready && !clr;
    assign w_out_xfer = bus.out_valid && bus.out_ready;

    // Next state and handshake/status outputs.
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = r_live && (r_state == LOAD_A || r_state == LOAD_B);
        bus.out_valid = r_state == DRAIN;
        bus.busy      = r_state == COMPUTE || r_state == DRAIN;
        bus.done      = r_state == DRAIN && w_out_xfer && w_last && !clr;
        bus.out_data  = r_state == DRAIN ? w_acc[r_cnt] : '0;
        if (clr) w_next = LOAD_A;
        else case (r_state)
            LOAD_A:  w_next = (w_in_xfer && w_last) ? LOAD_B : LOAD_A;
            LOAD_B:  w_next = (w_in_xfer && w_last) ? COMPUTE : LOAD_B;
            COMPUTE: w_next = w_cmp_end ? DRAIN : COMPUTE;
            default: w_next = (w_out_xfer && w_last) ? LOAD_A : DRAIN;
        endcase
    end

    // State, shared element/cycle counter and operand storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
            r_cnt   <= '0;
            r_live  <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            r_cnt   <= (clr || w_next != r_state) ? '0 :
                       (w_in_xfer || w_out_xfer || r_state == COMPUTE) ? r_cnt + 1'b1 : r_cnt;
            if (w_in_xfer && r_state == LOAD_A) r_a[r_cnt] <= bus.in_data;
            if (w_in_xfer && r_state == LOAD_B) r_b[r_cnt] <= bus.in_data;
        end
    end

    // Skewed edge feed: row i of A and column i of B start i cycles late, zero outside their window.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_al[i] = '0;
            w_bt[i] = '0;
            if (r_state == COMPUTE && int'(r_cnt) >= i && int'(r_cnt) - i < N) begin
                w_al[i] = r_a[CW'(i * N + int'(r_cnt) - i)];
                w_bt[i] = r_b[CW'((int'(r_cnt) - i) * N + i)];
            end
        end
    end

    // Operands leaving the right and bottom edges have no consumer.
    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < N; i++) w_unused = w_unused ^ (^w_ah[i][N-1]) ^ (^w_bv[N-1][i]);
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sysmm_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (r_state == COMPUTE),
                .clr_acc (r_state == LOAD_A),
                .a_in    (j == 0 ? w_al[i] : w_ah[i][j == 0 ? 0 : j-1]),
                .b_in    (i == 0 ? w_bt[j] : w_bv[i == 0 ? 0 : i-1][j]),
                .a_out   (w_ah[i][j]),
                .b_out   (w_bv[i][j]),
                .acc     (w_acc[i*N+j])
            );
        end
    end
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// tb_systolic_matmul_nxn: directed scoreboard bench for the systolic multiplier.
module tb_systolic_matmul_nxn;
    import sysmm_pkg::*;
    localparam int N = 2, DW = 4, NN = N * N, ACCW = acc_w(N, DW);

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    int checks = 0, errors = 0, done_cnt = 0;
    logic [ACCW-1:0] q[$];
    logic [DW-1:0] ma [NN];
    logic [DW-1:0] mb [NN];

    systolic_matmul_nxn_if #(.DW(DW), .ACCW(ACCW)) bus ();
    systolic_matmul_nxn #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit gap);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t == 50) check("in_ready_timeout", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
        if (gap) @(negedge clk);
    endtask

    task automatic load(input bit gap);
        logic [ACCW-1:0] s, p;
        for (int k = 0; k < NN; k++) send(ma[k], gap);
        for (int k = 0; k < NN; k++) send(mb[k], gap);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < N; k++) begin
`ifdef SYSMM_SIGNED_EN
                    p = $signed(ma[r*N+k]) * $signed(mb[k*N+c]);
`else
                    p = ma[r*N+k] * mb[k*N+c];
`endif
                    s = s + p;
                end
                q.push_back(s);
            end
    endtask

    task automatic drain(input int stall_at, input string tag);
        int t;
        bus.out_ready = 1'b1;
        for (int e = 0; e < NN; e++) begin
            t = 0;
            while (bus.out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            check({tag, "_valid"}, 32'(bus.out_valid), 1);
            if (q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(q.size()), 1);
                return;
            end
            if (e == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check({tag, "_stall"}, 32'(bus.out_data), 32'(q[0]));
                end
                bus.out_ready = 1'b1;
            end
            check(tag, 32'(bus.out_data), 32'(q.pop_front()));
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, d0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(bus.in_ready), 1);

        // Basic product, latency, in_valid ignored while busy, single done.
        ma = '{4'd1, 4'd2, 4'd3, 4'd4}; mb = '{4'd5, 4'd6, 4'd7, 4'd8};
        load(1'b0);
        bus.in_valid = 1'b1; bus.in_data = '1;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        check("latency", 32'(lat), 32'(3 * N - 2));
        drain(-1, "basic");
        bus.in_valid = 1'b0;
        check("basic_done_cnt", 32'(done_cnt), 1);
        check("basic_idle_ready", 32'(bus.in_ready), 1);

        // All-maximum operands.
        ma = '{4'd15, 4'd15, 4'd15, 4'd15}; mb = ma;
        load(1'b0);
        drain(-1, "max");

        // Throttled input and output backpressure.
        ma = '{4'd1, 4'd2, 4'd3, 4'd4}; mb = '{4'd5, 4'd6, 4'd7, 4'd8};
        load(1'b1);
        drain(1, "bp");

        // Soft clear mid-load.
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) send(4'd7, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 4'd3; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; bus.in_valid = 1'b0;
        check("clr_busy", 32'(bus.busy), 0);
        check("clr_in_ready", 32'(bus.in_ready), 1);
        check("clr_no_done", 32'(done_cnt), 32'(d0));
        ma = '{4'd1, 4'd0, 4'd0, 4'd1}; mb = '{4'd9, 4'd8, 4'd7, 4'd6};
        load(1'b0);
        drain(-1, "clr");
        check("clr_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        // Reset during compute discards the product.
        ma = '{4'd1, 4'd2, 4'd3, 4'd4}; mb = '{4'd5, 4'd6, 4'd7, 4'd8};
        load(1'b0);
        @(negedge clk);
        check("cmp_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_in_ready", 32'(bus.in_ready), 0);
        check("arst_busy", 32'(bus.busy), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_rel_ready", 32'(bus.in_ready), 1);
        load(1'b0);
        drain(-1, "post_rst");

        // Negated identity (all-ones diagonal) and all-zero operands.
        ma = '{4'd15, 4'd0, 4'd0, 4'd15}; mb = '{4'd1, 4'd2, 4'd3, 4'd4};
        load(1'b0);
        drain(-1, "neg_id");
        ma = '{4'd0, 4'd0, 4'd0, 4'd0}; mb = ma;
        load(1'b0);
        drain(-1, "zero");
        check("sb_empty_end", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
